// File: rtl/call_ret_sequencer.sv
// CALL/RET/GOTO control-flow sequencer driving a 2-level return stack and PC load/flush strobes.
// Optional sticky overflow/underflow flags are enabled with `define STK_GUARD_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 12
`endif
`ifndef STK_PUSH
`define STK_PUSH 2'b01
`endif
`ifndef STK_POP
`define STK_POP 2'b10
`endif

module call_ret_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 reqValid,
   input  logic [1:0]           reqOp,
   input  logic [`PC_WIDTH-1:0] reqTarget,
   input  logic [`PC_WIDTH-1:0] pcIn,
   output logic                 reqReady,
   input  logic [`PC_WIDTH-1:0] stkTopIn,
   output logic [1:0]           stkCmdOut,
   output logic [`PC_WIDTH-1:0] stkDataOut,
   output logic                 pcLoadOut,
   output logic [`PC_WIDTH-1:0] pcTargetOut,
   output logic                 flushOut,
   output logic [1:0]           depthOut,
   output logic                 ovfOut,
   output logic                 unfOut
);

   localparam int unsigned W = `PC_WIDTH;
   localparam logic [1:0] OP_CALL = 2'b01;
   localparam logic [1:0] OP_RET  = 2'b10;
   localparam logic [1:0] OP_GOTO = 2'b11;
   localparam logic [1:0] STK_NOP = 2'b00;
   localparam logic [1:0] DEPTH_MAX = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PUSH  = 3'd1,
      S_LOAD  = 3'd2,
      S_POP   = 3'd3,
      S_FLUSH = 3'd4
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   target_q, target_d;
   logic [W-1:0]   ret_q, ret_d;
   logic [1:0]     flush_cnt_q, flush_cnt_d;
   logic [1:0]     depth_q, depth_d;

   // State and datapath registers
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= S_IDLE;
         target_q    <= '0;
         ret_q       <= '0;
         flush_cnt_q <= '0;
         depth_q     <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         ret_q       <= ret_d;
         flush_cnt_q <= flush_cnt_d;
         depth_q     <= depth_d;
      end
   end

   // Next-state and latch/depth update
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      ret_d       = ret_q;
      flush_cnt_d = flush_cnt_q;
      depth_d     = depth_q;
      case (state_q)
         S_IDLE: begin
            if (reqValid) begin
               case (reqOp)
                  OP_CALL: begin
                     target_d = reqTarget;
                     ret_d    = pcIn + W'(1);
                     state_d  = S_PUSH;
                  end
                  OP_GOTO: begin
                     target_d = reqTarget;
                     state_d  = S_LOAD;
                  end
                  OP_RET:  state_d = S_POP;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_PUSH: begin
            depth_d = (depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_q + 2'd1;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
         end
         S_POP: begin
            depth_d     = (depth_q == 2'd0) ? 2'd0 : depth_q - 2'd1;
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
         end
         S_FLUSH: begin
            if (flush_cnt_q == 2'(FLUSH_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore output decode; POP forwards the live top-of-stack
   always_comb begin
      reqReady    = 1'b0;
      stkCmdOut   = STK_NOP;
      stkDataOut  = ret_q;
      pcLoadOut   = 1'b0;
      pcTargetOut = target_q;
      flushOut    = 1'b0;
      case (state_q)
         S_IDLE:  reqReady = 1'b1;
         S_PUSH:  stkCmdOut = `STK_PUSH;
         S_LOAD:  pcLoadOut = 1'b1;
         S_POP: begin
            stkCmdOut   = `STK_POP;
            pcLoadOut   = 1'b1;
            pcTargetOut = stkTopIn;
         end
         S_FLUSH: flushOut = 1'b1;
         default: reqReady = 1'b0;
      endcase
   end

   assign depthOut = depth_q;

`ifdef STK_GUARD_EN
   logic ovf_q, unf_q;

   // Sticky guard flags, cleared only by reset
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (state_q == S_PUSH && depth_q == DEPTH_MAX) ovf_q <= 1'b1;
         if (state_q == S_POP && depth_q == 2'd0)       unf_q <= 1'b1;
      end
   end

   assign ovfOut = ovf_q;
   assign unfOut = unf_q;
`else
   assign ovfOut = 1'b0;
   assign unfOut = 1'b0;
`endif

endmodule

// File: tb/tb_call_ret_sequencer.sv
// Self-checking bench for call_ret_sequencer: vector table with scoreboard, plus
// hand-written FLUSH_CYCLES=3 back-to-back and mid-PUSH reset sequences.
`ifndef PC_WIDTH
`define PC_WIDTH 12
`endif
`ifndef STK_PUSH
`define STK_PUSH 2'b01
`endif
`ifndef STK_POP
`define STK_POP 2'b10
`endif

module tb_call_ret_sequencer;
   localparam int unsigned W = `PC_WIDTH;
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_CALL = 2'b01;
   localparam logic [1:0] OP_RET  = 2'b10;
   localparam logic [1:0] OP_GOTO = 2'b11;
   localparam logic [1:0] C_PUSH  = `STK_PUSH;
   localparam logic [1:0] C_POP   = `STK_POP;
   localparam logic [1:0] C_NOP   = 2'b00;
   localparam int K_PUSH = 0;
   localparam int K_LOAD = 1;
   localparam int K_POP  = 2;
`ifdef STK_GUARD_EN
   localparam logic G = 1'b1;
`else
   localparam logic G = 1'b0;
`endif

   typedef struct {
      int           kind;
      logic [W-1:0] data;
   } ev_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] tgt;
      logic [W-1:0] pc;
      logic [W-1:0] top;
      int           lat;
      int           occ;
      logic [1:0]   depth;
      logic         ovf;
      logic         unf;
   } vec_t;

   logic         clk, rstN, reqValid1, reqValid3;
   logic [1:0]   reqOp;
   logic [W-1:0] reqTarget, pcIn, stkTopIn;
   logic         rdy1, load1, flush1, ovf1, unf1;
   logic [1:0]   cmd1, depth1;
   logic [W-1:0] data1, tgt1;
   logic         rdy3, load3, flush3, ovf3, unf3;
   logic [1:0]   cmd3, depth3;
   logic [W-1:0] data3, tgt3;

   int checks = 0;
   int failures = 0;
   ev_t sb[$];
   vec_t vecs[10];

   call_ret_sequencer #(.FLUSH_CYCLES(1)) u_dut1 (
      .clk(clk), .rstN(rstN), .reqValid(reqValid1), .reqOp(reqOp),
      .reqTarget(reqTarget), .pcIn(pcIn), .reqReady(rdy1), .stkTopIn(stkTopIn),
      .stkCmdOut(cmd1), .stkDataOut(data1), .pcLoadOut(load1), .pcTargetOut(tgt1),
      .flushOut(flush1), .depthOut(depth1), .ovfOut(ovf1), .unfOut(unf1)
   );

   call_ret_sequencer #(.FLUSH_CYCLES(3)) u_dut3 (
      .clk(clk), .rstN(rstN), .reqValid(reqValid3), .reqOp(reqOp),
      .reqTarget(reqTarget), .pcIn(pcIn), .reqReady(rdy3), .stkTopIn(stkTopIn),
      .stkCmdOut(cmd3), .stkDataOut(data3), .pcLoadOut(load3), .pcTargetOut(tgt3),
      .flushOut(flush3), .depthOut(depth3), .ovfOut(ovf3), .unfOut(unf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for the FLUSH_CYCLES=1 instance
   initial begin
      ev_t e;
      forever begin
         @(posedge clk);
         #3;
         if (rstN) begin
            if (cmd1 == C_PUSH) begin
               if (sb.size() == 0) check("sb_unexpected_push", 32'(1), 32'(0));
               else begin
                  e = sb.pop_front();
                  check("sb_push_kind", 32'(K_PUSH), 32'(e.kind));
                  check("sb_push_data", 32'(data1), 32'(e.data));
               end
            end else if (load1) begin
               if (sb.size() == 0) check("sb_unexpected_load", 32'(1), 32'(0));
               else begin
                  e = sb.pop_front();
                  check("sb_load_kind", (cmd1 == C_POP) ? 32'(K_POP) : 32'(K_LOAD), 32'(e.kind));
                  check("sb_load_target", 32'(tgt1), 32'(e.data));
               end
            end else if (cmd1 != C_NOP) begin
               check("sb_stray_cmd", 32'(cmd1), 32'(C_NOP));
            end
         end
      end
   end

   task automatic run_op(input vec_t v, input int idx);
      int lat, occ, fl, waitc;
      string p;
      p = $sformatf("v%0d", idx);
      lat = -1; occ = -1; fl = 0; waitc = 0;
      @(negedge clk);
      reqOp = v.op; reqTarget = v.tgt; pcIn = v.pc; stkTopIn = v.top; reqValid1 = 1'b1;
      while (!rdy1 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      check({p, "_ready"}, 32'(rdy1), 32'(1));
      @(posedge clk);
      case (v.op)
         OP_CALL: begin
            sb.push_back('{K_PUSH, W'(v.pc + 1)});
            sb.push_back('{K_LOAD, v.tgt});
         end
         OP_GOTO: sb.push_back('{K_LOAD, v.tgt});
         OP_RET:  sb.push_back('{K_POP, v.top});
         default: ;
      endcase
      #1;
      reqValid1 = 1'b0;
      reqTarget = W'($urandom);
      pcIn      = W'($urandom);
      for (int i = 1; i <= 12; i++) begin
         if (load1 && lat < 0) lat = i;
         if (flush1) fl++;
         if (rdy1) begin
            occ = i - 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({p, "_latency"}, 32'(lat), 32'(v.lat));
      check({p, "_occupancy"}, 32'(occ), 32'(v.occ));
      check({p, "_flush_cycles"}, 32'(fl), 32'(1));
      check({p, "_depth"}, 32'(depth1), 32'(v.depth));
      check({p, "_ovf"}, 32'(ovf1), 32'(v.ovf));
      check({p, "_unf"}, 32'(unf1), 32'(v.unf));
   endtask

   initial begin
      int loads;
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int loads;
      rstN = 1'b0; reqValid1 = 1'b0; reqValid3 = 1'b0; reqOp = OP_NONE;
      reqTarget = '0; pcIn = '0; stkTopIn = '0;

      vecs[0] = '{OP_CALL, W'('h200), W'('h010), W'('h000), 2, 3, 2'd1, 1'b0, 1'b0};
      vecs[1] = '{OP_RET,  W'('h000), W'('h000), W'('h011), 1, 2, 2'd0, 1'b0, 1'b0};
      vecs[2] = '{OP_CALL, W'('h300), W'('h100), W'('h000), 2, 3, 2'd1, 1'b0, 1'b0};
      vecs[3] = '{OP_CALL, W'('h400), W'('h300), W'('h000), 2, 3, 2'd2, 1'b0, 1'b0};
      vecs[4] = '{OP_CALL, W'('h500), W'('h400), W'('h000), 2, 3, 2'd2, G,    1'b0};
      vecs[5] = '{OP_RET,  W'('h000), W'('h000), W'('h401), 1, 2, 2'd1, G,    1'b0};
      vecs[6] = '{OP_RET,  W'('h000), W'('h000), W'('h301), 1, 2, 2'd0, G,    1'b0};
      vecs[7] = '{OP_RET,  W'('h000), W'('h000), W'('h0AB), 1, 2, 2'd0, G,    G   };
      vecs[8] = '{OP_GOTO, W'('h0FF), W'('h020), W'('h000), 1, 2, 2'd0, G,    G   };
      vecs[9] = '{OP_CALL, W'('h001), W'('hFFF), W'('h000), 2, 3, 2'd1, G,    G   };

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(rdy1), 32'(1));
      check("rst_cmd", 32'(cmd1), 32'(C_NOP));
      check("rst_load", 32'(load1), 32'(0));
      check("rst_flush", 32'(flush1), 32'(0));
      check("rst_depth", 32'(depth1), 32'(0));
      check("rst_ovf", 32'(ovf1), 32'(0));
      check("rst_unf", 32'(unf1), 32'(0));
      check("rst_ready3", 32'(rdy3), 32'(1));
      @(negedge clk);
      rstN = 1'b1;

      foreach (vecs[i]) run_op(vecs[i], i);

      // Valid with op 00 is ignored
      @(negedge clk);
      reqValid1 = 1'b1; reqOp = OP_NONE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("nop_ready", 32'(rdy1), 32'(1));
         check("nop_load", 32'(load1), 32'(0));
      end
      reqValid1 = 1'b0;
      check("nop_depth", 32'(depth1), 32'(1));

      // FLUSH_CYCLES=3: GOTO held valid back-to-back
      @(negedge clk);
      reqOp = OP_GOTO; reqTarget = W'('h0FF); reqValid3 = 1'b1;
      check("b2b_ready0", 32'(rdy3), 32'(1));
      @(posedge clk);
      #1;
      reqTarget = W'('h123);
      check("b2b_load1", 32'(load3), 32'(1));
      check("b2b_target1", 32'(tgt3), 32'('h0FF));
      check("b2b_ready1", 32'(rdy3), 32'(0));
      for (int c = 2; c <= 4; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("b2b_flush_c%0d", c), 32'(flush3), 32'(1));
         check($sformatf("b2b_busy_c%0d", c), 32'(rdy3 | load3), 32'(0));
      end
      @(posedge clk);
      #1;
      check("b2b_idle_ready", 32'(rdy3), 32'(1));
      check("b2b_idle_flush", 32'(flush3), 32'(0));
      check("b2b_idle_load", 32'(load3), 32'(0));
      @(posedge clk);
      #1;
      reqValid3 = 1'b0;
      check("b2b_load2", 32'(load3), 32'(1));
      check("b2b_target2", 32'(tgt3), 32'('h123));
      repeat (6) @(posedge clk);
      #1;
      check("b2b_final_ready", 32'(rdy3), 32'(1));
      check("b2b_depth", 32'(depth3), 32'(0));

      // Reset pulsed during the CALL PUSH cycle
      @(negedge clk);
      reqOp = OP_CALL; reqTarget = W'('h3AA); pcIn = W'('h050); reqValid1 = 1'b1;
      @(posedge clk);
      #1;
      reqValid1 = 1'b0;
      check("rstmid_push_cmd", 32'(cmd1), 32'(C_PUSH));
      check("rstmid_push_data", 32'(data1), 32'('h051));
      rstN = 1'b0;
      #1;
      check("rstmid_cmd", 32'(cmd1), 32'(C_NOP));
      check("rstmid_load", 32'(load1), 32'(0));
      @(negedge clk);
      rstN = 1'b1;
      loads = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (load1) loads++;
      end
      check("rstmid_no_load", 32'(loads), 32'(0));
      check("rstmid_depth", 32'(depth1), 32'(0));
      check("rstmid_ready", 32'(rdy1), 32'(1));
      check("rstmid_ovf", 32'(ovf1), 32'(0));
      check("rstmid_unf", 32'(unf1), 32'(0));

      @(posedge clk);
      #4;
      check("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
